// File: rtl/rvvi_seq_pkg.sv
// rvvi_seq_pkg: shared types and helpers for the RVVI retire sequencer.
// The record carries insn/pc at their widest supported widths (32/64);
// narrower ILEN/XLEN builds are zero-extended into these fields.
package rvvi_seq_pkg;

    localparam int MAX_NHART  = 8;
    localparam int MAX_RETIRE = 4;
    localparam int REC_ILEN   = 32;
    localparam int REC_XLEN   = 64;

    // One serialized retirement as seen by the coverage sampler.
    typedef struct packed {
        logic [2:0]          hart;
        logic [1:0]          slot;
        logic [REC_ILEN-1:0] insn;
        logic [REC_XLEN-1:0] pc;
        logic                trap;
    } rvvi_seq_rec_t;

    typedef struct packed {
        logic [2:0] hart;
        logic [1:0] slot;
    } rvvi_seq_hs_t;

    // Flat slot index (hart*RETIRE+slot) back to its {hart, slot} pair.
    function automatic rvvi_seq_hs_t slot_to_hs(input int idx, input int retire);
        rvvi_seq_hs_t hs;
        hs.hart = 3'(idx / retire);
        hs.slot = 2'(idx % retire);
        return hs;
    endfunction

endpackage

// File: rtl/rvvi_seq_fifo.sv
// rvvi_seq_fifo: multi-push, single-pop FIFO. The caller compacts the
// records to push into push_data[0 .. push_cnt-1] and guarantees that
// push_cnt never exceeds the free space (including a same-cycle pop), and
// that pop is only raised while out_valid is high.
module rvvi_seq_fifo
    import rvvi_seq_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int NPUSH = 1,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1,
    localparam int PW    = $clog2(NPUSH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  rvvi_seq_rec_t push_data [NPUSH],
    input  logic [PW-1:0] push_cnt,
    input  logic          pop,
    output logic          out_valid,
    output rvvi_seq_rec_t out_rec,
    output logic [CW-1:0] count
);

    rvvi_seq_rec_t r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage, pointers and count; reset discards everything held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NPUSH; i++) begin
                if (i < int'(push_cnt)) begin
                    r_mem[AW'(int'(r_wr_ptr) + i)] <= push_data[i];
                end
            end
            r_wr_ptr <= r_wr_ptr + AW'(push_cnt);
            r_rd_ptr <= r_rd_ptr + AW'(pop);
            r_count  <= r_count + CW'(push_cnt) - CW'(pop);
        end
    end

    // Head comes straight from registered storage, so no input reaches it
    // combinationally; it is held while the sampler stalls.
    assign out_valid = (r_count != '0);
    assign out_rec   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;

endmodule

// File: rtl/rvvi_retire_sequencer.sv
// rvvi_retire_sequencer: serializes every hart/retire slot of the RVVI
// trace into one ordered record stream. Valid slots are compacted
// hart-major starting at a round-robin hart, slot 0 first within a hart,
// and pushed into a FIFO; whatever does not fit is dropped and counted.
// Optional per-hart accepted-retirement counters: RVVI_SEQ_STATS_EN.
module rvvi_retire_sequencer
    import rvvi_seq_pkg::*;
#(
    parameter  int ILEN   = 32,
    parameter  int XLEN   = 64,
    parameter  int NHART  = 1,
    parameter  int RETIRE = 1,
    parameter  int DEPTH  = 16,
    localparam int NS     = NHART * RETIRE,
    localparam int CW     = $clog2(DEPTH) + 1,
    localparam int RW     = $bits(rvvi_seq_rec_t)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NS-1:0]        in_valid,
    input  logic [NS*ILEN-1:0]   in_insn,
    input  logic [NS*XLEN-1:0]   in_pc,
    input  logic [NS-1:0]        in_trap,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RW-1:0]        out_rec,
    output logic [CW-1:0]        occupancy,
    output logic                 overflow,
    output logic [15:0]          drop_count,
    output logic [NHART*32-1:0]  retired_count
);

    localparam int PW  = $clog2(NS + 1);
    localparam int SIW = (NS > 1) ? $clog2(NS) : 1;
    localparam int HW  = (NHART > 1) ? $clog2(NHART) : 1;

    rvvi_seq_rec_t w_slot_rec  [NS];
    rvvi_seq_rec_t w_push_data [NS];
    rvvi_seq_rec_t w_head;
    logic [PW-1:0] w_push_cnt;
    logic [PW-1:0] w_drop_cnt;
    logic [CW-1:0] w_count;
    logic          w_fifo_valid;
    logic          w_pop;
    logic [16:0]   w_drop_sum;
    logic [HW-1:0] r_rr_ptr;
    logic          r_overflow;
    logic [15:0]   r_drop_count;
`ifdef RVVI_SEQ_STATS_EN
    logic [2:0]    w_hart_acc [NHART];
    logic [31:0]   r_retired  [NHART];
`endif

    // Per-slot record with its fixed {hart, slot} tag.
    for (genvar g = 0; g < NS; g++) begin : g_slot
        localparam rvvi_seq_hs_t HS = slot_to_hs(g, RETIRE);
        assign w_slot_rec[g] = '{hart: HS.hart,
                                 slot: HS.slot,
                                 insn: REC_ILEN'(in_insn[g*ILEN +: ILEN]),
                                 pc:   REC_XLEN'(in_pc[g*XLEN +: XLEN]),
                                 trap: in_trap[g]};
    end

    // A pop this cycle frees its entry for this cycle's pushes.
    assign w_pop = w_fifo_valid & out_ready;

    // Round-robin compaction: fill free space in push order, drop the rest.
    always_comb begin
        int v_free;
        int v_pos;
        int v_nvalid;
        int v_h;
        int v_idx;
        v_free   = DEPTH - int'(w_count) + int'(w_pop);
        v_pos    = 0;
        v_nvalid = 0;
        v_h      = 0;
        v_idx    = 0;
        for (int p = 0; p < NS; p++) begin
            w_push_data[p] = '0;
        end
`ifdef RVVI_SEQ_STATS_EN
        for (int h = 0; h < NHART; h++) begin
            w_hart_acc[h] = '0;
        end
`endif
        for (int k = 0; k < NHART; k++) begin
            v_h = (int'(r_rr_ptr) + k) % NHART;
            for (int s = 0; s < RETIRE; s++) begin
                v_idx = v_h * RETIRE + s;
                if (in_valid[SIW'(v_idx)]) begin
                    v_nvalid = v_nvalid + 1;
                    if (v_pos < v_free) begin
                        w_push_data[SIW'(v_pos)] = w_slot_rec[SIW'(v_idx)];
                        v_pos = v_pos + 1;
`ifdef RVVI_SEQ_STATS_EN
                        w_hart_acc[HW'(v_h)] = w_hart_acc[HW'(v_h)] + 3'd1;
`endif
                    end
                end
            end
        end
        w_push_cnt = PW'(v_pos);
        w_drop_cnt = PW'(v_nvalid - v_pos);
    end

    rvvi_seq_fifo #(
        .DEPTH (DEPTH),
        .NPUSH (NS)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_data (w_push_data),
        .push_cnt  (w_push_cnt),
        .pop       (w_pop),
        .out_valid (w_fifo_valid),
        .out_rec   (w_head),
        .count     (w_count)
    );

    assign w_drop_sum = {1'b0, r_drop_count} + 17'(w_drop_cnt);

    // Round-robin pointer moves only when something was enqueued; drop
    // tracking saturates and the overflow flag is sticky until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr     <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_push_cnt != '0) begin
                r_rr_ptr <= HW'((int'(r_rr_ptr) + 1) % NHART);
            end
            if (w_drop_cnt != '0) begin
                r_overflow <= 1'b1;
            end
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

`ifdef RVVI_SEQ_STATS_EN
    // Per-hart wrapping count of accepted (not dropped) retirements.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int h = 0; h < NHART; h++) begin
                r_retired[h] <= '0;
            end
        end else begin
            for (int h = 0; h < NHART; h++) begin
                r_retired[h] <= r_retired[h] + 32'(w_hart_acc[h]);
            end
        end
    end

    for (genvar h = 0; h < NHART; h++) begin : g_stats
        assign retired_count[h*32 +: 32] = r_retired[h];
    end
`else
    assign retired_count = '0;
`endif

    assign out_valid  = w_fifo_valid;
    assign out_rec    = w_head;
    assign occupancy  = w_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_rvvi_retire_sequencer.sv
// Bench for rvvi_retire_sequencer with NHART=2, RETIRE=2, DEPTH=8.
// Slot index = hart*2 + slot. Expected records are queued by the driver
// in hand-computed push order; a negedge monitor pops and compares.
module tb_rvvi_retire_sequencer;
  import rvvi_seq_pkg::*;

  localparam int NHART  = 2;
  localparam int RETIRE = 2;
  localparam int DEPTH  = 8;
  localparam int NS     = NHART * RETIRE;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int REC_W  = $bits(rvvi_seq_rec_t);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NS-1:0]     in_valid = '0;
  logic [NS*32-1:0]  in_insn = '0;
  logic [NS*64-1:0]  in_pc = '0;
  logic [NS-1:0]     in_trap = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [REC_W-1:0]  out_rec;
  logic [CW-1:0]     occupancy;
  logic              overflow;
  logic [15:0]       drop_count;
  logic [NHART*32-1:0] retired_count;

  logic [REC_W-1:0]  exp_q[$];
  int                n_cmp = 0;
  int                n_bad = 0;

  rvvi_retire_sequencer #(
    .ILEN(32), .XLEN(64), .NHART(NHART), .RETIRE(RETIRE), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_insn(in_insn),
    .in_pc(in_pc), .in_trap(in_trap), .out_valid(out_valid),
    .out_ready(out_ready), .out_rec(out_rec), .occupancy(occupancy),
    .overflow(overflow), .drop_count(drop_count), .retired_count(retired_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] insn_of(input logic [63:0] base, input int idx);
    return {base[23:0], 8'(idx)};
  endfunction

  function automatic logic [63:0] pc_of(input logic [63:0] base, input int idx);
    return base + 64'(4 * idx);
  endfunction

  function automatic logic [REC_W-1:0] mk_rec(input logic [63:0] base, input int idx);
    return {3'(idx / RETIRE), 2'(idx % RETIRE), insn_of(base, idx), pc_of(base, idx), (idx == 3)};
  endfunction

  // driver: one cycle of stimulus; order lists expected accepted slots MSB nibble first
  task automatic drive(input logic [3:0] mask, input logic [63:0] base, input logic rdy,
                       input int n_exp, input logic [15:0] order);
    for (int i = 0; i < NS; i++) begin
      in_insn[i*32 +: 32] = insn_of(base, i);
      in_pc[i*64 +: 64]   = pc_of(base, i);
      in_trap[i]          = (i == 3);
    end
    in_valid  = mask;
    out_ready = rdy;
    for (int j = 0; j < n_exp; j++) begin
      logic [3:0] id;
      id = order[15 - 4*j -: 4];
      exp_q.push_back(mk_rec(base, int'(id)));
    end
    @(posedge clk); #1;
    in_valid = '0;
  endtask

  task automatic idle(input int n, input logic rdy);
    out_ready = rdy;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [REC_W-1:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rec", out_rec, '0);
        end else begin
          e = exp_q.pop_front();
          check("rec", out_rec, e);
        end
      end
    end
  end

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_out_rec", out_rec, 0);
    check("rst_retired", retired_count, 0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // single slot, back to back, popped the cycle after each push
    drive(4'b0001, 64'h8000_0000, 1'b1, 1, 16'h0000);
    check("ss_valid_latency", out_valid, 1);
    check("ss_occ1", occupancy, 1);
    drive(4'b0001, 64'h8000_0004, 1'b1, 1, 16'h0000);
    drive(4'b0001, 64'h8000_0008, 1'b1, 1, 16'h0000);
    drive(4'b0001, 64'h8000_000C, 1'b1, 1, 16'h0000);
    check("ss_occ_steady", occupancy, 1);
    idle(1, 1'b1);
    check("ss_drained_valid", out_valid, 0);
    check("ss_overflow", overflow, 0);

    // round robin across harts (rr_ptr back at hart 0)
    drive(4'b1111, 64'h1000_0000, 1'b1, 4, 16'h0123);
    drive(4'b1111, 64'h1000_0100, 1'b1, 4, 16'h2301);
    check("rr_occ", occupancy, 7);
    idle(7, 1'b1);
    check("rr_drained", occupancy, 0);

    // overflow with the sampler stalled
    drive(4'b1111, 64'h2000_0000, 1'b0, 4, 16'h0123);
    drive(4'b1111, 64'h2000_0100, 1'b0, 4, 16'h2301);
    drive(4'b0011, 64'h2000_0200, 1'b0, 0, 16'h0000);
    check("ovf_occ", occupancy, 8);
    check("ovf_drop", drop_count, 2);
    check("ovf_flag", overflow, 1);
`ifdef RVVI_SEQ_STATS_EN
    check("ovf_ret_h0", retired_count[31:0], 12);
    check("ovf_ret_h1", retired_count[63:32], 8);
`else
    check("ovf_ret_off", retired_count, 0);
`endif

    // full with simultaneous pop: only slot 1 (first in order) fits
    drive(4'b0110, 64'h3000_0000, 1'b1, 1, 16'h1000);
    check("fp_occ", occupancy, 8);
    check("fp_drop", drop_count, 3);
    idle(8, 1'b1);
    check("fp_drained", occupancy, 0);
    check("fp_ovf_sticky", overflow, 1);

    // reset mid-stream (rr_ptr at hart 1)
    drive(4'b0111, 64'h4000_0000, 1'b0, 3, 16'h2010);
    check("mr_occ", occupancy, 3);
    #2 reset_n = 1'b0;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_occ0", occupancy, 0);
    check("mr_ovf", overflow, 0);
    check("mr_drop", drop_count, 0);
    exp_q.delete();
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    drive(4'b0001, 64'h5000_0000, 1'b1, 1, 16'h0000);
    check("mr_post_valid", out_valid, 1);
    idle(1, 1'b1);

    // statistics: hart 1 retires 5, one dropped (rr_ptr at hart 1)
    drive(4'b1111, 64'h6000_0000, 1'b0, 4, 16'h2301);
    drive(4'b1111, 64'h6000_0100, 1'b0, 4, 16'h0123);
    drive(4'b0100, 64'h6000_0200, 1'b0, 0, 16'h0000);
    check("st_drop", drop_count, 1);
    check("st_occ", occupancy, 8);
`ifdef RVVI_SEQ_STATS_EN
    check("st_ret_h0", retired_count[31:0], 5);
    check("st_ret_h1", retired_count[63:32], 4);
`else
    check("st_ret_off", retired_count, 0);
`endif
    idle(9, 1'b1);
    check("st_drained", occupancy, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rvvi_retire_sequencer.md
# rvvi_retire_sequencer

Serializes retirements from every hart and retire slot of the RVVI trace into one ordered stream of single-instruction records. It sits between the `rvviTrace` interface and the coverage sampler, so the sampler can handle `NHART>1` and `RETIRE>1` while still sampling one instruction per call. The trace cannot be back-pressured, so the block buffers retirements in a FIFO, drops whatever does not fit, and counts the drops.

## Interface
- `ILEN`, default 32: instruction width.
- `XLEN`, default 64: PC width.
- `NHART`, default 1: number of harts, 1..8.
- `RETIRE`, default 1: retire slots per hart, 1..4.
- `DEPTH`, default 16: FIFO entries; power of 2, at least `NHART*RETIRE`.

Ports:
- `clk`  in  1  trace clock (the same clock as `rvvi.clk`).
- `reset_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  `NHART*RETIRE`  retire valid; index = `hart*RETIRE+slot`.
- `in_insn`  in  `NHART*RETIRE*ILEN`  instruction per slot.
- `in_pc`  in  `NHART*RETIRE*XLEN`  `pc_rdata` per slot.
- `in_trap`  in  `NHART*RETIRE`  trap flag per slot.
- `out_valid`  out  1  record available.
- `out_ready`  in  1  sampler accepts the record.
- `out_rec`  out  `$bits(rvvi_seq_rec_t)`  record fields: hart, slot, insn, pc, trap.
- `occupancy`  out  `$clog2(DEPTH)+1`  current FIFO count.
- `overflow`  out  1  sticky; set on the first dropped retirement.
- `drop_count`  out  16  number of dropped retirements; saturates at `0xFFFF`.
- `retired_count`  out  `NHART*32`  per-hart accepted retirement count (see Configuration).

## Operation
- **Push order each cycle.**
  - Valid slots are pushed hart-major, starting at hart `rr_ptr` and wrapping modulo `NHART`.
  - Within a hart, slots are pushed in ascending order (slot 0 first), which matches program order.
- **Round-robin pointer.**
  - `rr_ptr` advances by 1 (mod `NHART`) in every cycle where at least one slot is pushed.
  - `rr_ptr` is unchanged in idle cycles.
- **Free space.** `free = DEPTH - count + pop`, where `pop = out_valid & out_ready`. A pop in the same cycle frees its entry for a push in that cycle.
- **Overflow.**
  - When the valid slots exceed `free`, the first `free` slots in push order are enqueued and the remaining slots are dropped.
  - `drop_count` increases by the number dropped, saturating at `0xFFFF`.
  - `overflow` is set and stays set until reset.
- **Pop.** When `out_valid & out_ready`, the head record is removed. `out_rec` holds steady while `out_valid & !out_ready`.
- **Pointers.** Read and write pointers are `$clog2(DEPTH)` bits wide and wrap naturally.
- **Count.** `count` updates as `count + pushed - pop`. It never exceeds `DEPTH` and never goes below 0.

## Timing
- **Reset values.** All of the following are 0: `out_valid`, `out_rec`, `occupancy`, `overflow`, `drop_count`, `retired_count`, `rr_ptr`, and both pointers. Reset clears the FIFO immediately, including mid-stream, and loses any records it held.
- **Latency.** A retirement presented in cycle N appears at the FIFO head no earlier than cycle N+1. There is no combinational path from `in_*` to `out_*`.
- **Throughput.** One record is popped per cycle. Up to `NHART*RETIRE` records are pushed per cycle.
- **Empty FIFO.** A push in cycle N with `count==0` gives `out_valid=1` in cycle N+1. A pop with no push that leaves `count==0` gives `out_valid=0` in the next cycle.
- **Full FIFO with simultaneous pop.** With `count==DEPTH` and a pop in the same cycle, exactly one incoming slot is accepted.
- **`occupancy`.** Registered; it reflects `count` after the cycle's update.

## Configuration
- **`RVVI_SEQ_STATS_EN` defined:**
  - One 32-bit wrapping counter per hart, incremented by that hart's accepted (not dropped) pushes in each cycle.
  - The counters are exposed on `retired_count`.
- **Undefined:** the counters are not built and `retired_count` is tied to 0.

## Structure
- **Package `rvvi_seq_pkg`** contains:
  - the `rvvi_seq_rec_t` packed struct: `hart` (3 bits), `slot` (2 bits), `insn`, `pc`, `trap`;
  - the `MAX_NHART` and `MAX_RETIRE` constants;
  - a function that converts a slot index to `{hart, slot}`.
- **Sub-module `rvvi_seq_fifo`:** a multi-push, single-pop FIFO that takes a compacted push vector and a push count.
- **Top level** owns:
  - the round-robin compaction;
  - the overflow, drop and statistics logic.

## Test plan
- **Single slot.** With `NHART=1`, `RETIRE=1`, push PC `0x80000000..0x8000000C` on consecutive cycles with `out_ready=1` → four records in the same order, each one cycle after its push, and `overflow=0`.
- **Round-robin across harts.** With `NHART=2`, `RETIRE=2`, all four slots valid for 2 cycles → output order is h0s0, h0s1, h1s0, h1s1, then h1s0, h1s1, h0s0, h0s1.
- **Overflow.** With `DEPTH=4`, `out_ready=0`, 4 slots valid in cycle 1 and 2 slots valid in cycle 2 → `occupancy=4`, `drop_count=2`, `overflow=1`, and the original 4 records are retained.
- **Full with simultaneous pop.** `count==DEPTH`, `out_ready=1`, 2 valid slots → 1 slot accepted, `drop_count` increases by 1, `occupancy` stays at `DEPTH`.
- **Reset mid-stream.** Assert `reset_n=0` asynchronously with `occupancy=3` → `out_valid` and `occupancy` go to 0 immediately; after release, the next push appears one cycle later.
- **Statistics.** With `RVVI_SEQ_STATS_EN` defined, hart 1 retires 5 instructions, one of which is dropped → `retired_count[1]=4`.
